oc_vc_credit_bridge: RTL and testbench

//  Credit-managed, buffered bridge for one OpenCAPI virtual channel between a TL-side

---
 rtl/oc_bridge_pkg.sv | 12 +
 rtl/oc_vc_credit_bridge_if.sv | 29 ++
 rtl/oc_sync_fifo.sv | 40 ++++
 rtl/oc_vc_credit_bridge.sv | 66 ++++++
 tb/tb_oc_vc_credit_bridge.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/oc_bridge_pkg.sv
// oc_bridge_pkg: shared state type, default widths and pointer-width helper
// for the OpenCAPI virtual-channel credit bridge.
package oc_bridge_pkg;
    typedef enum logic [1:0] {INIT, LOAD, RUN, RESYNC} bridge_state_e;
    localparam int CRED_W_DEF = 7;
    localparam int DN_ICW_DEF = 4;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/oc_vc_credit_bridge_if.sv
// oc_vc_credit_bridge_if: producer/consumer handshake bundle of one virtual channel;
// slave is the bridge's view, master the surrounding driver's view.
interface oc_vc_credit_bridge_if
    import oc_bridge_pkg::*;
#(
    parameter int PAYLOAD_W = 128,
    parameter int CRED_W    = CRED_W_DEF,
    parameter int DN_ICW    = DN_ICW_DEF
);
    logic                 up_valid;
    logic [PAYLOAD_W-1:0] up_payload;
    logic                 up_credit;
    logic [CRED_W-1:0]    up_initial_credit;
    logic                 dn_valid;
    logic [PAYLOAD_W-1:0] dn_payload;
    logic                 dn_credit;
    logic [DN_ICW-1:0]    dn_initial_credit;
    logic                 resync;
    logic [CRED_W-1:0]    credit_cnt;
    logic                 err_overflow;
    modport slave (
        input  up_valid, up_payload, dn_credit, dn_initial_credit, resync,
        output up_credit, up_initial_credit, dn_valid, dn_payload, credit_cnt, err_overflow
    );
    modport master (
        output up_valid, up_payload, dn_credit, dn_initial_credit, resync,
        input  up_credit, up_initial_credit, dn_valid, dn_payload, credit_cnt, err_overflow
    );
endinterface

// File: rtl/oc_sync_fifo.sv
// oc_sync_fifo: synchronous FIFO without bypass; pointers carry an extra lap bit
// so full/empty come straight from the pointer compare.
module oc_sync_fifo
    import oc_bridge_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = clog2(DEPTH);
    logic [AW:0]  wp, rp;
    logic [W-1:0] mem [DEPTH];
    // Index wraps at DEPTH-1 and flips the lap bit, so non-power-of-two depths work too.
    function automatic logic [AW:0] nxt(input logic [AW:0] p);
        return p[AW-1:0] == AW'(DEPTH - 1) ? {~p[AW], AW'(0)} : p + 1'b1;
    endfunction
    assign empty = wp == rp;
    assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign head  = mem[rp[AW-1:0]];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= nxt(wp);
            if (pop && !empty) rp <= nxt(rp);
        end
    end
    always_ff @(posedge clock) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/oc_vc_credit_bridge.sv
// oc_vc_credit_bridge: buffered, credit-managed bridge for one virtual channel,
// holding the upstream credit grant and the downstream credit pool.
module oc_vc_credit_bridge
    import oc_bridge_pkg::*;
#(
    parameter int PAYLOAD_W = 128,
    parameter int DEPTH     = 8,
    parameter int CRED_W    = CRED_W_DEF,
    parameter int DN_ICW    = DN_ICW_DEF
) (
    input logic                    clock,
    input logic                    reset_n,
    oc_vc_credit_bridge_if.slave   bus
);
    localparam logic [CRED_W-1:0] CMAX = '1;
    bridge_state_e        state, state_nx;
    logic                 full, empty, pop, cnt_ovf;
    logic [PAYLOAD_W-1:0] head;
    logic [CRED_W-1:0]    cnt_nx;
    oc_sync_fifo #(.W(PAYLOAD_W), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (bus.up_valid),
        .pop     (pop),
        .din     (bus.up_payload),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );
    assign pop     = (state == RUN || state == RESYNC) && !empty && bus.credit_cnt != '0;
    assign cnt_ovf = state != LOAD && bus.dn_credit && !pop && bus.credit_cnt == CMAX;
    // The reload in LOAD overrides any returning dn_credit.
    assign cnt_nx  = state == LOAD ? CRED_W'(bus.dn_initial_credit) :
                     cnt_ovf       ? bus.credit_cnt :
                     bus.credit_cnt + CRED_W'(bus.dn_credit) - CRED_W'(pop);
    always_comb begin
        state_nx = state;
        case (state)
            INIT:    state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = bus.resync ? RESYNC : RUN;
            RESYNC:  state_nx = empty && !bus.dn_valid ? LOAD : RESYNC;
            default: state_nx = INIT;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= INIT;
            bus.credit_cnt        <= '0;
            bus.up_initial_credit <= '0;
            bus.dn_valid          <= 1'b0;
            bus.dn_payload        <= '0;
            bus.up_credit         <= 1'b0;
            bus.err_overflow      <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.credit_cnt <= cnt_nx;
            bus.dn_valid   <= pop;
            bus.up_credit  <= pop;
            if (pop) bus.dn_payload <= head;
            if (state == LOAD) bus.up_initial_credit <= CRED_W'(DEPTH);
            // Full is judged before this cycle's pop, so a push into a full FIFO is always dropped.
            bus.err_overflow <= bus.err_overflow | (bus.up_valid & full) | cnt_ovf;
        end
    end
endmodule

// File: tb/tb_oc_vc_credit_bridge.sv
// tb_oc_vc_credit_bridge: directed scenarios plus random traffic, scored against a
// queue-and-counter reference model of the channel.
module tb_oc_vc_credit_bridge;
    localparam int DEPTH = 8;
    localparam int PW    = 128;
    localparam int CMAX  = 127;
    typedef logic [PW-1:0] pl_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    oc_vc_credit_bridge_if #(.PAYLOAD_W(PW), .CRED_W(7), .DN_ICW(4)) bus ();
    oc_vc_credit_bridge #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .CRED_W(7), .DN_ICW(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int  n_chk, n_pass;
    int  dv_seen, uc_seen;
    pl_t q[$];
    int  phase, cred, m_uic;
    bit  m_err, m_dv, m_uc;
    pl_t m_pl;

    task automatic chk(input string tag, input pl_t got, input pl_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic pl_t rand_pl();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // phase: 0 after reset, 1 loading, 2 running, 3 resyncing
    task automatic model_reset();
        q.delete();
        phase = 0; cred = 0; m_uic = 0;
        m_err = 0; m_dv = 0; m_uc = 0; m_pl = '0;
    endtask

    task automatic model_step();
        bit iss, was_full, drained;
        iss      = (phase == 2 || phase == 3) && q.size() > 0 && cred > 0;
        was_full = q.size() >= DEPTH;
        drained  = q.size() == 0 && !m_dv;
        m_dv = iss;
        m_uc = iss;
        if (iss) m_pl = q.pop_front();
        if (phase == 1) begin
            cred  = int'(bus.dn_initial_credit);
            m_uic = DEPTH;
        end else if (bus.dn_credit && !iss && cred == CMAX) m_err = 1;
        else cred = cred + int'(bus.dn_credit) - int'(iss);
        if (bus.up_valid) begin
            if (was_full) m_err = 1;
            else q.push_back(bus.up_payload);
        end
        phase = phase == 0 ? 1 : phase == 1 ? 2 : phase == 2 ? (bus.resync ? 3 : 2) : (drained ? 1 : 3);
    endtask

    task automatic check_all();
        chk("dn_valid", pl_t'(bus.dn_valid), pl_t'(m_dv));
        chk("up_credit", pl_t'(bus.up_credit), pl_t'(m_uc));
        chk("credit_cnt", pl_t'(bus.credit_cnt), pl_t'(cred));
        chk("err_overflow", pl_t'(bus.err_overflow), pl_t'(m_err));
        chk("up_initial_credit", pl_t'(bus.up_initial_credit), pl_t'(m_uic));
        if (m_dv) chk("dn_payload", bus.dn_payload, m_pl);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        if (bus.dn_valid) dv_seen++;
        if (bus.up_credit) uc_seen++;
        check_all();
    endtask

    task automatic idle();
        bus.up_valid  = 1'b0;
        bus.dn_credit = 1'b0;
        bus.resync    = 1'b0;
    endtask

    task automatic push(input pl_t p);
        bus.up_valid   = 1'b1;
        bus.up_payload = p;
        cycle();
        bus.up_valid   = 1'b0;
    endtask

    task automatic release_reset(input int icr);
        bus.dn_initial_credit = 4'(icr);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cycle();
        cycle();
        chk("init_credit_cnt", pl_t'(bus.credit_cnt), pl_t'(icr));
        chk("init_up_credit", pl_t'(bus.up_initial_credit), pl_t'(DEPTH));
    endtask

    task automatic do_reset(input int icr);
        idle();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_dn_payload", bus.dn_payload, '0);
        release_reset(icr);
    endtask

    initial begin
        idle();
        bus.up_payload        = '0;
        bus.dn_initial_credit = '0;
        model_reset();
        @(negedge clock);
        do_reset(4);

        dv_seen = 0; uc_seen = 0;
        for (int i = 0; i < 6; i++) push(rand_pl());
        repeat (6) cycle();
        chk("t2_issued", pl_t'(dv_seen), pl_t'(4));
        chk("t2_cnt_zero", pl_t'(bus.credit_cnt), pl_t'(0));
        repeat (2) begin
            bus.dn_credit = 1'b1; cycle();
            bus.dn_credit = 1'b0; cycle();
        end
        repeat (4) cycle();
        chk("t2_issued_all", pl_t'(dv_seen), pl_t'(6));
        chk("t2_up_credits", pl_t'(uc_seen), pl_t'(6));

        for (int i = 0; i < 9; i++) begin
            push(rand_pl());
            if (i == 7) chk("t3_no_err_at_8", pl_t'(bus.err_overflow), pl_t'(0));
        end
        chk("t3_err_at_9", pl_t'(bus.err_overflow), pl_t'(1));
        bus.dn_credit = 1'b1;
        repeat (12) cycle();
        idle();
        repeat (3) cycle();

        do_reset(0);
        for (int i = 0; i < 8; i++) push(rand_pl());
        bus.dn_credit = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            bus.up_valid   = i > 0;
            bus.up_payload = rand_pl();
            cycle();
            chk("t4_cnt_one", pl_t'(bus.credit_cnt), pl_t'(1));
            chk("t4_issue", pl_t'(bus.dn_valid), pl_t'(1));
        end
        idle();
        repeat (3) cycle();
        bus.dn_credit = 1'b1;
        repeat (10) cycle();
        idle();

        do_reset(0);
        dv_seen = 0;
        for (int i = 0; i < 3; i++) push(rand_pl());
        bus.dn_initial_credit = 4'd2;
        bus.resync = 1'b1;
        cycle();
        bus.resync = 1'b0;
        repeat (3) begin
            bus.dn_credit = 1'b1; cycle();
            bus.dn_credit = 1'b0; cycle();
        end
        repeat (4) cycle();
        chk("t5_drained", pl_t'(dv_seen), pl_t'(3));
        chk("t5_reloaded", pl_t'(bus.credit_cnt), pl_t'(2));

        do_reset(4);
        bus.up_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.up_payload = rand_pl();
            cycle();
        end
        chk("t6_dv_before", pl_t'(bus.dn_valid), pl_t'(1));
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_dv", pl_t'(bus.dn_valid), pl_t'(0));
        chk("t6_async_uc", pl_t'(bus.up_credit), pl_t'(0));
        chk("t6_async_cnt", pl_t'(bus.credit_cnt), pl_t'(0));
        chk("t6_async_uic", pl_t'(bus.up_initial_credit), pl_t'(0));
        idle();
        model_reset();
        release_reset(4);
        dv_seen = 0;
        repeat (5) cycle();
        chk("t6_no_stale", pl_t'(dv_seen), pl_t'(0));

        do_reset(15);
        bus.dn_credit = 1'b1;
        repeat (112) cycle();
        chk("t7_cnt_max", pl_t'(bus.credit_cnt), pl_t'(CMAX));
        chk("t7_no_err", pl_t'(bus.err_overflow), pl_t'(0));
        cycle();
        chk("t7_err", pl_t'(bus.err_overflow), pl_t'(1));
        chk("t7_hold", pl_t'(bus.credit_cnt), pl_t'(CMAX));
        idle();

        do_reset(int'($urandom_range(0, 15)));
        for (int i = 0; i < 400; i++) begin
            bus.up_valid          = 1'($urandom_range(0, 1));
            bus.up_payload        = rand_pl();
            bus.dn_credit         = $urandom_range(0, 2) == 0;
            bus.resync            = $urandom_range(0, 29) == 0;
            bus.dn_initial_credit = 4'($urandom_range(0, 15));
            cycle();
        end
        idle();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
